// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-cold column scan, 2-flop row sync, frame debounce, ghost rejection.
// Optional key FIFO is built only when KEYPAD_FIFO_EN is defined.
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SCAN_CYCLES    = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int CODE_W         = $clog2(ROWS*COLS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ROWS-1:0]   i_row,
  output logic [COLS-1:0]   o_col,
  output logic [CODE_W-1:0] o_key_code,
  output logic              o_key_valid,
  output logic              o_key_press,
  output logic              o_key_release,
  output logic              o_multi,
  input  logic              i_pop,
  output logic [CODE_W-1:0] o_fifo_data,
  output logic              o_fifo_empty,
  output logic              o_fifo_overflow
);

  localparam int NBITS = ROWS * COLS;
  localparam int CW    = $clog2(COLS);
  localparam int DW    = $clog2(SCAN_CYCLES);
  localparam int SW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [SW-1:0] STAB_MAX   = SW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_e;
  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_MULTI} state_e;

  logic [ROWS-1:0]   row_s1_q, row_s2_q;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [CW-1:0]     col_idx_q, col_idx_d;
  logic [COLS-1:0]   col_q, col_d;
  logic [NBITS-1:0]  frame_q, frame_d;
  logic              dwell_last, col_last, frame_end;

  logic              any_hit, multi_hit;
  logic [CODE_W-1:0] hit_code, cls_code;
  cls_e              cls;

  cls_e              prev_cls_q, prev_cls_d;
  logic [CODE_W-1:0] prev_code_q, prev_code_d;
  logic [SW-1:0]     stab_q, stab_d;
  logic              same_cls, accept;

  state_e            state_q;
  logic [CODE_W-1:0] key_code_q;
  logic              key_valid_q, key_press_q, key_release_q, multi_q;

  // o_col lags col_idx by one cycle, so the dwell window seen on the pins still spans
  // SCAN_CYCLES cycles and the last-dwell sample sees rows settled through the sync.
  always_comb begin
    dwell_last = (dwell_q == DWELL_LAST);
    col_last   = (col_idx_q == COL_LAST);
    frame_end  = dwell_last && col_last;
    dwell_d    = dwell_last ? '0 : dwell_q + 1'b1;
    col_idx_d  = col_idx_q;
    if (dwell_last) begin
      col_idx_d = col_last ? '0 : col_idx_q + 1'b1;
    end
    col_d   = ~(COLS'(1) << col_idx_q);
    frame_d = frame_q;
    if (dwell_last) begin
      frame_d[int'(col_idx_q)*ROWS +: ROWS] = ~row_s2_q;
    end
  end

  always_comb begin
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    hit_code  = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (frame_d[c*ROWS + r]) begin
          if (any_hit) multi_hit = 1'b1;
          any_hit  = 1'b1;
          hit_code = CODE_W'(r*COLS + c);
        end
      end
    end
    if (multi_hit) begin
      cls      = CLS_MULTI;
      cls_code = '0;
    end else if (any_hit) begin
      cls      = CLS_SINGLE;
      cls_code = hit_code;
    end else begin
      cls      = CLS_NONE;
      cls_code = '0;
    end
  end

  // Acceptance fires only on the frame where the stability count first reaches the limit.
  always_comb begin
    same_cls    = (cls == prev_cls_q) && (cls_code == prev_code_q);
    stab_d      = stab_q;
    prev_cls_d  = prev_cls_q;
    prev_code_d = prev_code_q;
    accept      = 1'b0;
    if (frame_end) begin
      if (!same_cls) begin
        stab_d = SW'(1);
      end else if (stab_q != STAB_MAX) begin
        stab_d = stab_q + 1'b1;
      end
      prev_cls_d  = cls;
      prev_code_d = cls_code;
      accept      = (stab_d == STAB_MAX) && !(same_cls && (stab_q == STAB_MAX));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_s1_q    <= '1;
      row_s2_q    <= '1;
      dwell_q     <= '0;
      col_idx_q   <= '0;
      col_q       <= '1;
      frame_q     <= '0;
      prev_cls_q  <= CLS_NONE;
      prev_code_q <= '0;
      stab_q      <= '0;
    end else begin
      row_s1_q    <= i_row;
      row_s2_q    <= row_s1_q;
      dwell_q     <= dwell_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      frame_q     <= frame_d;
      prev_cls_q  <= prev_cls_d;
      prev_code_q <= prev_code_d;
      stab_q      <= stab_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      multi_q       <= 1'b0;
    end else begin
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      if (accept) begin
        case (state_q)
          ST_IDLE: begin
            if (cls == CLS_SINGLE) begin
              state_q     <= ST_PRESSED;
              key_code_q  <= cls_code;
              key_valid_q <= 1'b1;
              key_press_q <= 1'b1;
            end else if (cls == CLS_MULTI) begin
              state_q <= ST_MULTI;
              multi_q <= 1'b1;
            end
          end
          ST_PRESSED: begin
            if (cls == CLS_SINGLE) begin
              if (cls_code != key_code_q) begin
                key_code_q  <= cls_code;
                key_press_q <= 1'b1;
              end
            end else if (cls == CLS_NONE) begin
              state_q       <= ST_IDLE;
              key_valid_q   <= 1'b0;
              key_release_q <= 1'b1;
            end else begin
              state_q     <= ST_MULTI;
              key_valid_q <= 1'b0;
              multi_q     <= 1'b1;
            end
          end
          ST_MULTI: begin
            // Ghost protection: only a fully released matrix leaves MULTI.
            if (cls == CLS_NONE) begin
              state_q <= ST_IDLE;
              multi_q <= 1'b0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_col         = col_q;
  assign o_key_code    = key_code_q;
  assign o_key_valid   = key_valid_q;
  assign o_key_press   = key_press_q;
  assign o_key_release = key_release_q;
  assign o_multi       = multi_q;

`ifdef KEYPAD_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;

  logic [CODE_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0]     count_q, count_d, occ_after_pop;
  logic [CODE_W-1:0] head_q, head_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, full, push_ok;

  // A push into a full FIFO only survives when a pop frees a slot in the same cycle.
  always_comb begin
    push          = key_press_q;
    pop           = i_pop && (count_q != '0);
    full          = (count_q == OW'(FIFO_DEPTH));
    push_ok       = push && (!full || pop);
    overflow_d    = overflow_q || (push && full && !pop);
    wr_d          = wr_q + AW'(push_ok);
    rd_d          = rd_q + AW'(pop);
    occ_after_pop = count_q - OW'(pop);
    count_d       = occ_after_pop + OW'(push_ok);
    if (occ_after_pop == '0) begin
      head_d = push_ok ? key_code_q : '0;
    end else begin
      head_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      head_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) mem_q[wr_q] <= key_code_q;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
      head_q     <= head_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_fifo_data     = head_q;
  assign o_fifo_empty    = (count_q == '0);
  assign o_fifo_overflow = overflow_q;
`else
  logic unused_fifo;
  assign unused_fifo     = i_pop & (FIFO_DEPTH > 0);
  assign o_fifo_data     = '0;
  assign o_fifo_empty    = 1'b1;
  assign o_fifo_overflow = 1'b0;
`endif

endmodule
